// File: rtl/float_fixed_conv_arbiter_if.sv
// Request/response and converter-side signals of the shared float->fixed converter arbiter.
// The arbiter uses the slave modport; requesters and the converter model use master.
interface float_fixed_conv_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [21:0]         rsp_data;
    logic                rsp_err;
    logic                conv_enable;
    logic [31:0]         conv_data;
    logic                conv_done;
    logic [21:0]         conv_result;
    logic                busy;
    logic [ID_W-1:0]     active_id;

    modport slave (
        input  req_valid, req_data, conv_done, conv_result,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               conv_enable, conv_data, busy, active_id
    );

    modport master (
        output req_valid, req_data, conv_done, conv_result,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               conv_enable, conv_data, busy, active_id
    );
endinterface

// File: rtl/float_fixed_conv_arbiter.sv
// Round-robin arbiter sharing one float->fixed converter; grant->response 2 edges with a 1-edge done.
// No queuing: one conversion in flight, losers hold req_valid until req_ready; hung converter times out.
module float_fixed_conv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                             clk,
    input  logic                             rst_n,
    float_fixed_conv_arbiter_if.slave        bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                enable_q, enable_d;
    logic [31:0]         data_q, data_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [N_REQ-1:0]    ready_q, ready_d;
    logic [N_REQ-1:0]    rsp_vld_q, rsp_vld_d;
    logic [21:0]         rsp_dat_q, rsp_dat_d;
    logic                rsp_err_q, rsp_err_d;
    logic                busy_q, busy_d;

    logic [31:0]         req_word [N_REQ];
    logic [ID_W-1:0]     scan_idx;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     next_ptr;
    logic                grant_found;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_word[g] = bus.req_data[32*g +: 32];
    end

    // Scan from the highest offset down so the last hit is the first valid at or after ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan_idx = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
        next_ptr = ID_W'((int'(grant_id) + 1) % N_REQ);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        enable_d  = enable_q;
        data_d    = data_q;
        id_d      = id_q;
        ready_d   = '0;
        rsp_vld_d = '0;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            ST_IDLE: begin
                // A done still high from the previous job blocks new grants.
                if (!bus.conv_done && grant_found) begin
                    data_d            = req_word[grant_id];
                    id_d              = grant_id;
                    ready_d[grant_id] = 1'b1;
                    enable_d          = 1'b1;
                    ptr_d             = next_ptr;
                    cnt_d             = '0;
                    state_d           = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.conv_done) begin
                    rsp_dat_d       = bus.conv_result;
                    rsp_vld_d[id_q] = 1'b1;
                    rsp_err_d       = 1'b0;
                    enable_d        = 1'b0;
                    state_d         = ST_DRAIN;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rsp_dat_d       = '0;
                    rsp_vld_d[id_q] = 1'b1;
                    rsp_err_d       = 1'b1;
                    enable_d        = 1'b0;
                    state_d         = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                enable_d = 1'b0;
                if (!bus.conv_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            enable_q  <= 1'b0;
            data_q    <= '0;
            id_q      <= '0;
            ready_q   <= '0;
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            enable_q  <= enable_d;
            data_q    <= data_d;
            id_q      <= id_d;
            ready_q   <= ready_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.rsp_valid   = rsp_vld_q;
    assign bus.rsp_data    = rsp_dat_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.conv_enable = enable_q;
    assign bus.conv_data   = data_q;
    assign bus.busy        = busy_q;
    assign bus.active_id   = id_q;

endmodule

// File: tb/tb_float_fixed_conv_arbiter.sv
// Random and directed stimulus for the converter arbiter, checked against a transaction-level model.
module tb_float_fixed_conv_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    float_fixed_conv_arbiter_if #(.N_REQ(N), .ID_W(IDW)) bus ();

    float_fixed_conv_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference value of the conversion: sign-magnitude, 20 fraction bits, zero above 1.x * 2^0.
    function automatic logic [21:0] ref_fix(input logic [31:0] d);
        int  e;
        int  m;
        real v;
        e = int'(d[30:23]);
        if (e > 127) return 22'd0;
        v = (1.0 + real'(d[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        m = $rtoi(v * 1048576.0);
        return {d[31], 21'(m)};
    endfunction

    function automatic logic [21:0] conv_shift(input logic [31:0] d);
        logic [23:0] mag;
        int          sh;
        if (d[30:23] > 8'd127) return 22'd0;
        sh  = 130 - int'(d[30:23]);
        mag = (sh >= 24) ? 24'd0 : ({1'b1, d[22:0]} >> sh);
        return {d[31], mag[20:0]};
    endfunction

    function automatic logic [31:0] rand_float();
        return {1'($urandom), 8'($urandom_range(105, 130)), 23'($urandom)};
    endfunction

    // Converter model: 0 = real (done follows enable by one edge), 1 = done stuck 0, 2 = done stuck 1.
    int          mode = 0;
    logic        cdone;
    logic [21:0] cres;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdone <= 1'b0;
            cres  <= 22'd0;
        end else begin
            case (mode)
                0:       cdone <= bus.conv_enable;
                1:       cdone <= 1'b0;
                default: cdone <= 1'b1;
            endcase
            cres <= conv_shift(bus.conv_data);
        end
    end
    assign bus.conv_done   = cdone;
    assign bus.conv_result = cres;

    // Transaction-level reference: one job in flight, fixed response/idle offsets per converter mode.
    int          edge_n = 0;
    bit          mon_on = 0;
    int          mptr = 0, free_edge = 0, g_edge = 0, idle_edge = 0;
    bit          pend_vld = 0;
    int          pend_id = 0, pend_edge = 0;
    logic [31:0] pend_data;
    bit          pend_err;
    int          rsp_cnt = 0;
    logic [21:0] last_rsp = '0;
    logic        last_err = 1'b0;
    int          obs_id[$];
    int          obs_edge[$];

    logic [N-1:0]   cap_v, exp_rdy, exp_rsp;
    logic [32*N-1:0] cap_d;
    logic           cap_done;
    int             cap_mode, e, win;

    always @(posedge clk) begin
        edge_n++;
        if (rst_n && mon_on) begin
            e        = edge_n;
            cap_v    = bus.req_valid;
            cap_d    = bus.req_data;
            cap_done = bus.conv_done;
            cap_mode = mode;
            #2;
            if (rst_n) begin
                exp_rdy = '0;
                exp_rsp = '0;
                if (pend_vld && e == pend_edge) begin
                    exp_rsp[pend_id] = 1'b1;
                    check("rsp_data", 32'(bus.rsp_data), pend_err ? 32'd0 : 32'(ref_fix(pend_data)));
                    check("rsp_err", 32'(bus.rsp_err), 32'(pend_err));
                    pend_vld = 0;
                end
                if (e >= free_edge && !cap_done && cap_v != '0) begin
                    win = -1;
                    for (int i = 0; i < N; i++)
                        if (win < 0 && cap_v[(mptr + i) % N]) win = (mptr + i) % N;
                    exp_rdy[win] = 1'b1;
                    mptr      = (win + 1) % N;
                    pend_vld  = 1;
                    pend_id   = win;
                    pend_data = cap_d[32*win +: 32];
                    pend_err  = (cap_mode != 0);
                    pend_edge = e + ((cap_mode == 0) ? 2 : TO);
                    idle_edge = pend_edge + ((cap_mode == 0) ? 2 : 1);
                    free_edge = idle_edge + 1;
                    g_edge    = e;
                    check("conv_data", bus.conv_data, pend_data);
                    check("active_id", 32'(bus.active_id), 32'(win));
                    check("conv_enable", 32'(bus.conv_enable), 32'd1);
                end
                check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
                check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
                check("busy", 32'(bus.busy), 32'(e >= g_edge && e < idle_edge));
                for (int i = 0; i < N; i++) begin
                    if (bus.req_ready[i]) begin
                        obs_id.push_back(i);
                        obs_edge.push_back(e);
                    end
                end
                if (bus.rsp_valid != '0) begin
                    rsp_cnt++;
                    last_rsp = bus.rsp_data;
                    last_err = bus.rsp_err;
                end
            end
        end
    end

    task automatic drive_cycle(input bit all_mode);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) begin
                if (all_mode || $urandom_range(0, 1) == 0) begin
                    bus.req_data[32*i +: 32] = rand_float();
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end else if (bus.req_valid[i]) begin
                if (!all_mode && $urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
            end else if (all_mode || $urandom_range(0, 3) == 0) begin
                bus.req_valid[i]         = 1'b1;
                bus.req_data[32*i +: 32] = rand_float();
            end
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        @(negedge clk);
        bus.req_valid = '0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!pend_vld && edge_n >= free_edge) begin
                ok = 1;
                break;
            end
        end
        check("idle_wait", 32'(ok), 32'd1);
    endtask

    task automatic single_req(input int id, input logic [31:0] d,
                              input logic [21:0] exp_dat, input logic exp_err);
        int c0;
        bit ok;
        ok = 0;
        @(negedge clk);
        c0 = rsp_cnt;
        bus.req_data[32*id +: 32] = d;
        bus.req_valid[id]         = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.req_ready[id]) bus.req_valid[id] = 1'b0;
            if (rsp_cnt != c0) begin
                ok = 1;
                break;
            end
        end
        check("rsp_seen", 32'(ok), 32'd1);
        check("dir_data", 32'(last_rsp), 32'(exp_dat));
        check("dir_err", 32'(last_err), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit ok;
        rst_n         = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_conv_enable", 32'(bus.conv_enable), 32'd0);
        check("rst_active_id", 32'(bus.active_id), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        repeat (2) @(negedge clk);

        // Everyone requesting continuously from reset release.
        rst_n  = 1'b1;
        mon_on = 1;
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = 1'b1;
            bus.req_data[32*i +: 32] = rand_float();
        end
        repeat (40) drive_cycle(1'b1);
        check("fair_count", 32'(obs_id.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("fair_order", 32'(obs_id[i]), 32'(i % N));
            if (i > 0) check("fair_gap", 32'(obs_edge[i] - obs_edge[i-1]), 32'd5);
        end
        wait_idle();

        single_req(0, 32'h3F80_0000, 22'h10_0000, 1'b0);
        single_req(1, 32'hBF00_0000, 22'h28_0000, 1'b0);
        single_req(2, 32'h3F00_0000, 22'h08_0000, 1'b0);
        single_req(3, 32'h4000_0000, 22'h00_0000, 1'b0);
        wait_idle();

        repeat (400) drive_cycle(1'b0);
        wait_idle();

        // Converter that never answers.
        mode = 1;
        single_req(1, rand_float(), 22'h00_0000, 1'b1);
        wait_idle();
        mode = 0;

        // Done stuck high while idle must block every grant.
        mode = 2;
        repeat (2) @(negedge clk);
        n0            = obs_id.size();
        bus.req_valid = '1;
        repeat (20) @(negedge clk);
        check("stale_grants", 32'(obs_id.size()), 32'(n0));
        bus.req_valid = '0;
        mode          = 0;
        repeat (3) @(negedge clk);

        // Reset while waiting on a hung converter.
        wait_idle();
        mode = 1;
        @(negedge clk);
        bus.req_data[64 +: 32] = rand_float();
        bus.req_valid[2]       = 1'b1;
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.req_ready[2]) begin
                ok = 1;
                break;
            end
        end
        check("pre_reset_grant", 32'(ok), 32'd1);
        bus.req_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        check("wait_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_enable", 32'(bus.conv_enable), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_rsp", 32'(bus.rsp_valid), 32'd0);
        pend_vld  = 0;
        mptr      = 0;
        free_edge = 0;
        g_edge    = 0;
        idle_edge = 0;
        n0        = rsp_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mode  = 0;
        repeat (25) @(negedge clk);
        check("post_rst_no_rsp", 32'(rsp_cnt), 32'(n0));

        // Pointer restarts at 0 after reset.
        n0 = obs_id.size();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = 1'b1;
            bus.req_data[32*i +: 32] = rand_float();
        end
        repeat (12) drive_cycle(1'b1);
        check("post_rst_first", 32'(obs_id.size() > n0 ? obs_id[n0] : -1), 32'd0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
